// File: rtl/crt_timing_gen_if.sv
// Raster timing bundle between the CRT timing generator and the pixel renderer.
// The generator owns the master side: it takes the divider setting and drives the timing.
interface crt_timing_gen_if #(
   parameter int unsigned CoordWidth = 10,
   parameter int unsigned DivWidth   = 4
);
   logic [DivWidth-1:0]   ClockDivide;
   logic                  PixelClock;
   logic [CoordWidth-1:0] xpos;
   logic [CoordWidth-1:0] ypos;
   logic                  hsync;
   logic                  vsync;
   logic                  ActiveVideo;
   logic                  LineEnd;
   logic                  FrameEnd;

   modport master (
      input  ClockDivide,
      output PixelClock, xpos, ypos, hsync, vsync, ActiveVideo, LineEnd, FrameEnd
   );

   modport slave (
      output ClockDivide,
      input  PixelClock, xpos, ypos, hsync, vsync, ActiveVideo, LineEnd, FrameEnd
   );
endinterface

// File: rtl/crt_timing_gen.sv
// Parametrised VGA/CRT raster timing generator with a runtime clock-enable divider.
// Coordinates and sync/active flags are registered; strobes are decoded from the registers.
module crt_timing_gen #(
   parameter int unsigned CoordWidth    = 10,
   parameter int unsigned DivWidth      = 4,
   parameter int unsigned HActive       = 640,
   parameter int unsigned HFront        = 16,
   parameter int unsigned HSync         = 96,
   parameter int unsigned HBack         = 48,
   parameter int unsigned VActive       = 480,
   parameter int unsigned VFront        = 10,
   parameter int unsigned VSync         = 2,
   parameter int unsigned VBack         = 33,
   parameter int unsigned HSyncPolarity = 0,
   parameter int unsigned VSyncPolarity = 0
) (
   input  logic           Clock,
   input  logic           Reset,
   crt_timing_gen_if.master tg
);

   localparam int unsigned HTotal  = HActive + HFront + HSync + HBack;
   localparam int unsigned VTotal  = VActive + VFront + VSync + VBack;
   localparam int unsigned HsStart = HActive + HFront;
   localparam int unsigned HsEnd   = HsStart + HSync;
   localparam int unsigned VsStart = VActive + VFront;
   localparam int unsigned VsEnd   = VsStart + VSync;
   localparam logic        HsPol   = 1'(HSyncPolarity);
   localparam logic        VsPol   = 1'(VSyncPolarity);

   // Reject parameter sets that cannot be represented or have empty mandatory regions.
   if (CoordWidth < 1 || CoordWidth > 31) begin : g_bad_coord_width
      $error("crt_timing_gen: CoordWidth must be 1..31");
   end
   if (DivWidth < 1 || DivWidth > 31) begin : g_bad_div_width
      $error("crt_timing_gen: DivWidth must be 1..31");
   end
   if (HActive < 1 || HSync < 1 || VActive < 1 || VSync < 1) begin : g_bad_regions
      $error("crt_timing_gen: HActive, HSync, VActive and VSync must be at least 1");
   end
   if (((HTotal - 1) >> CoordWidth) != 0 || ((VTotal - 1) >> CoordWidth) != 0) begin : g_bad_totals
      $error("crt_timing_gen: HTotal-1 or VTotal-1 does not fit in CoordWidth");
   end
   if (HSyncPolarity > 1 || VSyncPolarity > 1) begin : g_bad_polarity
      $error("crt_timing_gen: sync polarity must be 0 or 1");
   end

   logic [DivWidth-1:0]   div_q, div_d, div_m1;
   logic [CoordWidth-1:0] x_q, x_d, y_q, y_d;
   logic                  hs_q, hs_d, vs_q, vs_d, av_q, av_d;
   logic                  pix_c, last_x_c, last_y_c;

   function automatic logic in_range(input logic [CoordWidth-1:0] v,
                                     input int unsigned lo, input int unsigned hi);
      return (32'(v) >= lo) && (32'(v) < hi);
   endfunction

   // Divider: a setting of 0 behaves as 1; a setting lowered below the count wraps it.
   always_comb begin
      div_m1 = '0;
      if (tg.ClockDivide != '0) begin
         div_m1 = tg.ClockDivide - DivWidth'(1);
      end
      pix_c    = (div_q == div_m1);
      div_d    = (div_q >= div_m1) ? '0 : div_q + DivWidth'(1);
      last_x_c = (x_q == CoordWidth'(HTotal - 1));
      last_y_c = (y_q == CoordWidth'(VTotal - 1));
   end

   // Raster next state; flags are decoded from the next coordinates so they stay aligned.
   always_comb begin
      x_d  = x_q;
      y_d  = y_q;
      hs_d = hs_q;
      vs_d = vs_q;
      av_d = av_q;
      if (pix_c) begin
         x_d = last_x_c ? '0 : x_q + CoordWidth'(1);
         if (last_x_c) begin
            y_d = last_y_c ? '0 : y_q + CoordWidth'(1);
         end
         hs_d = in_range(x_d, HsStart, HsEnd) ? HsPol : ~HsPol;
         vs_d = in_range(y_d, VsStart, VsEnd) ? VsPol : ~VsPol;
         av_d = (32'(x_d) < HActive) && (32'(y_d) < VActive);
      end
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         div_q <= '0;
         x_q   <= '0;
         y_q   <= '0;
         hs_q  <= ~HsPol;
         vs_q  <= ~VsPol;
         av_q  <= 1'b1;
      end else begin
         div_q <= div_d;
         x_q   <= x_d;
         y_q   <= y_d;
         hs_q  <= hs_d;
         vs_q  <= vs_d;
         av_q  <= av_d;
      end
   end

   assign tg.PixelClock  = pix_c;
   assign tg.xpos        = x_q;
   assign tg.ypos        = y_q;
   assign tg.hsync       = hs_q;
   assign tg.vsync       = vs_q;
   assign tg.ActiveVideo = av_q;
   assign tg.LineEnd     = pix_c & last_x_c;
   assign tg.FrameEnd    = pix_c & last_x_c & last_y_c;

endmodule

// File: doc/crt_timing_gen.md
# crt_timing_gen

Parametrised VGA/CRT raster timing generator, successor to the fixed-porch CRT controller. It produces the hsync and vsync pulses, raster coordinates, an active-video flag, and line-end and frame-end strobes from one system clock. The pixel rate comes from a runtime-programmable clock-enable divider. Every horizontal and vertical timing region and each sync polarity is a parameter, so one RTL body covers the 640x480 board mode and the small simulation modes. The block sits between the system clock and the pixel/sprite renderer of the Pong display path.

## Interface
- CoordWidth, 10, width of xpos/ypos; HTotal-1 and VTotal-1 must fit
- DivWidth, 4, width of ClockDivide
- HActive, 640, visible pixels per line (>=1)
- HFront, 16, horizontal front porch pixels (>=0)
- HSync, 96, hsync pulse pixels (>=1)
- HBack, 48, horizontal back porch pixels (>=0)
- VActive, 480, visible lines (>=1)
- VFront, 10; VSync, 2 (>=1); VBack, 33, vertical equivalents in lines
- HSyncPolarity, 0, asserted level of hsync (0 = active-low)
- VSyncPolarity, 0, asserted level of vsync
- Clock  input  1  system clock, all logic on rising edge
- Reset  input  1  synchronous, active-high
- ClockDivide  input  DivWidth  system clocks per pixel; 0 treated as 1
- PixelClock  output  1  one-Clock pixel enable strobe
- xpos  output  CoordWidth  horizontal counter, 0..HTotal-1
- ypos  output  CoordWidth  vertical counter, 0..VTotal-1
- hsync  output  1  horizontal sync at HSyncPolarity when asserted
- vsync  output  1  vertical sync at VSyncPolarity when asserted
- ActiveVideo  output  1  high when xpos<HActive and ypos<VActive
- LineEnd  output  1  one-Clock strobe on the last pixel of a line
- FrameEnd  output  1  one-Clock strobe on the last pixel of a frame

## Operation
- HTotal = HActive+HFront+HSync+HBack. VTotal = VActive+VFront+VSync+VBack. Each line runs active, front porch, sync, back porch, and each frame follows the same order.
- Divider: register DivCount, D = max(ClockDivide,1). PixelClock = (DivCount == D-1), decoded from the register. On PixelClock DivCount goes to 0, otherwise it increments. ClockDivide is sampled every cycle. If a change drops D to DivCount or below, the next compare fails to match, so DivCount also wraps to 0 when DivCount >= D-1.
- Horizontal: xpos increments on each PixelClock. At HTotal-1 it wraps to 0.
- Vertical: ypos increments only on a PixelClock where xpos == HTotal-1. At VTotal-1 it wraps to 0.
- hsync, vsync and ActiveVideo are registered. On each PixelClock they load the values decoded from the next xpos/ypos, so they always match the xpos/ypos presented in the same cycle.
- hsync is asserted for HActive+HFront <= xpos < HActive+HFront+HSync. vsync is asserted for VActive+VFront <= ypos < VActive+VFront+VSync. The output level is the polarity parameter when asserted and its inverse otherwise.
- LineEnd = PixelClock && xpos == HTotal-1.
- FrameEnd = LineEnd && ypos == VTotal-1.
- Between PixelClock strobes, all counters and registered outputs hold.
- A parameter set that violates the width or minimum rules is a configuration error. The implementation raises an elaboration-time error for it.

## Timing
- Reset values: DivCount=0, xpos=0, ypos=0, ActiveVideo=1, hsync=~HSyncPolarity, vsync=~VSyncPolarity. PixelClock, LineEnd and FrameEnd are 0 unless D=1, where PixelClock is high in the first cycle after Reset.
- Reset asserted mid-frame takes effect at the next edge and overrides any PixelClock in that cycle.
- The first PixelClock comes in the D-th Clock cycle after Reset deasserts.
- Coordinates update one Clock edge after the PixelClock cycle, so each coordinate is held for exactly D Clocks.
- A line is HTotal*D Clocks and a frame is HTotal*VTotal*D Clocks.
- LineEnd and FrameEnd are coincident with PixelClock and are never wider than one Clock.

## Test plan
Small mode for all scenarios: HActive=8, HFront=1, HSync=2, HBack=1, VActive=4, VFront=2, VSync=1, VBack=3. This gives HTotal=12 and VTotal=10.
- ClockDivide=1, run 2 frames: PixelClock high every cycle. hsync=0 exactly at xpos 9,10. vsync=0 exactly at ypos 6. LineEnd every 12 Clocks. FrameEnd every 120 Clocks.
- ClockDivide=4: PixelClock every 4th Clock, first in cycle 4 after Reset. Each xpos is held 4 Clocks. FrameEnd period is 480 Clocks.
- ClockDivide=0: behaviour identical to ClockDivide=1.
- HSyncPolarity=1, VSyncPolarity=1: hsync=1 only at xpos 9,10 and vsync=1 only at ypos 6. ActiveVideo=1 exactly for xpos<8 and ypos<4, which is 32 pixels per frame.
- Reset asserted at (xpos=5, ypos=7) with D=3: the next cycle shows xpos=0, ypos=0, DivCount=0, ActiveVideo=1 and sync outputs inactive. The first PixelClock follows 3 cycles after Reset deasserts.
- ClockDivide changed from 8 to 2 while DivCount=5: DivCount wraps to 0 with no skipped or doubled xpos step. The period is then 2 Clocks.
